// File: rtl/tree_key_scheduler_if.sv
// Bundle of requester, tree and result signals for tree_key_scheduler.
// The slave modport is the scheduler's view; master is the surrounding
// environment (requesters, tree pipeline and result consumer).
interface tree_key_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 13
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                   enable;
  logic [NUM_REQ-1:0]     req_valid;
  logic [16*NUM_REQ-1:0]  req_key;
  logic [NUM_REQ-1:0]     req_ready;
  logic [15:0]            tree_key_out;
  logic                   tree_index_out;
  logic                   tree_valid_out;
  logic                   tree_valid_in;
  logic [IDX_W-1:0]       tree_index_in;
  logic                   res_valid;
  logic                   res_ready;
  logic [ID_W-1:0]        res_id;
  logic [IDX_W-1:0]       res_index;
  logic                   idle;
  logic                   err;

  modport slave (
    input  enable, req_valid, req_key, tree_valid_in, tree_index_in, res_ready,
    output req_ready, tree_key_out, tree_index_out, tree_valid_out,
           res_valid, res_id, res_index, idle, err
  );

  modport master (
    output enable, req_valid, req_key, tree_valid_in, tree_index_in, res_ready,
    input  req_ready, tree_key_out, tree_index_out, tree_valid_out,
           res_valid, res_id, res_index, idle, err
  );
endinterface

// File: rtl/tree_key_scheduler.sv
// Round-robin key scheduler in front of a fixed-latency classification tree.
// Grants one requester per cycle, tags each key with its requester ID in an
// in-order ID FIFO, and pairs returning leaf indices with those IDs in a
// first-word-fall-through result FIFO. Issue is credit-limited so the
// non-stallable tree can never overflow the result FIFO.
// Optional feature: define TREE_SCHED_STATS_EN to add saturating
// stat_issued / stat_stall counters as extra output ports.
module tree_key_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int TOTAL_LEVEL = 12,
  parameter int MAX_INFLT   = 16,
  parameter int RES_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tree_key_scheduler_if.slave  bus
`ifdef TREE_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall
`endif
);
  localparam int IDX_W = TOTAL_LEVEL + 1;
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IF_AW = (MAX_INFLT > 1) ? $clog2(MAX_INFLT) : 1;
  localparam int RF_AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int IF_CW = IF_AW + 1;
  localparam int RF_CW = RF_AW + 1;
  localparam int RES_W = ID_W + IDX_W;
  localparam logic [RF_CW-1:0] RES_FULL = RF_CW'(RES_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [IF_CW-1:0]  r_inflight;
  logic [RF_CW-1:0]  r_res_count;
  logic [IF_AW-1:0]  r_id_wr;
  logic [IF_AW-1:0]  r_id_rd;
  logic [RF_AW-1:0]  r_res_wr;
  logic [RF_AW-1:0]  r_res_rd;
  logic              r_tree_valid;
  logic [15:0]       r_tree_key;
  logic              r_err;
  logic [ID_W-1:0]   r_id_mem  [MAX_INFLT];
  logic [RES_W-1:0]  r_res_mem [RES_DEPTH];

  logic [15:0]        w_keys [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W-1:0]    w_scan_idx;
  logic               w_found;
  logic               w_issue;
  logic               w_credit_ok;
  logic               w_res_nempty;
  logic               w_res_full;
  logic               w_res_pop;
  logic               w_res_push;
  logic               w_tree_err;
  logic [RES_W-1:0]   w_head;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_key
    assign w_keys[gi] = bus.req_key[16*gi +: 16];
  end

  // Keys in the tree plus results already queued must leave room in the result FIFO.
  assign w_credit_ok = ((32'(r_inflight) + 32'(r_res_count)) < 32'(RES_DEPTH)) &&
                       (32'(r_inflight) < 32'(MAX_INFLT));

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_scan_idx  = '0;
    w_found     = 1'b0;
    if (r_state == S_RUN && w_credit_ok) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_found && bus.req_valid[w_scan_idx]) begin
          w_found              = 1'b1;
          w_grant[w_scan_idx]  = 1'b1;
          w_grant_idx          = w_scan_idx;
        end
      end
    end
  end

  assign w_issue      = |(bus.req_valid & w_grant);
  assign w_res_nempty = (r_res_count != '0);
  assign w_res_full   = (r_res_count == RES_FULL);
  assign w_res_pop    = w_res_nempty && bus.res_ready;
  // A full FIFO that is popping in the same cycle can still take the result.
  assign w_tree_err   = bus.tree_valid_in &&
                        ((r_inflight == '0) || (w_res_full && !w_res_pop));
  assign w_res_push   = bus.tree_valid_in && !w_tree_err;
  assign w_head       = r_res_mem[r_res_rd];

  assign bus.req_ready      = w_grant;
  assign bus.tree_key_out   = r_tree_key;
  assign bus.tree_index_out = 1'b0;
  assign bus.tree_valid_out = r_tree_valid;
  assign bus.res_valid      = w_res_nempty;
  assign bus.res_id         = w_res_nempty ? w_head[RES_W-1:IDX_W] : '0;
  assign bus.res_index      = w_res_nempty ? w_head[IDX_W-1:0] : '0;
  assign bus.idle           = (r_state == S_IDLE);
  assign bus.err            = r_err;

  // Run/drain/idle control; enable wins over drain completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.enable) r_state <= S_RUN;
        S_RUN:   if (!bus.enable) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (bus.enable)               r_state <= S_RUN;
          else if (r_inflight == '0)    r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Issue path, FIFO pointers, occupancy counters and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr     <= ID_W'(NUM_REQ - 1);
      r_tree_valid <= 1'b0;
      r_tree_key   <= '0;
      r_id_wr      <= '0;
      r_id_rd      <= '0;
      r_res_wr     <= '0;
      r_res_rd     <= '0;
      r_inflight   <= '0;
      r_res_count  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_tree_valid <= w_issue;
      if (w_issue) begin
        r_tree_key <= w_keys[w_grant_idx];
        r_rr_ptr   <= w_grant_idx;
        r_id_wr    <= r_id_wr + IF_AW'(1);
      end
      if (w_res_push) begin
        r_id_rd  <= r_id_rd + IF_AW'(1);
        r_res_wr <= r_res_wr + RF_AW'(1);
      end
      if (w_res_pop) r_res_rd <= r_res_rd + RF_AW'(1);
      case ({w_issue, w_res_push})
        2'b10:   r_inflight <= r_inflight + IF_CW'(1);
        2'b01:   r_inflight <= r_inflight - IF_CW'(1);
        default: ;
      endcase
      case ({w_res_push, w_res_pop})
        2'b10:   r_res_count <= r_res_count + RF_CW'(1);
        2'b01:   r_res_count <= r_res_count - RF_CW'(1);
        default: ;
      endcase
      if (w_tree_err) r_err <= 1'b1;
    end
  end

  // ID tag storage, written in issue order.
  always_ff @(posedge clk) begin
    if (w_issue) r_id_mem[r_id_wr] <= w_grant_idx;
  end

  // Result storage: oldest tag paired with the returning leaf index.
  always_ff @(posedge clk) begin
    if (w_res_push) r_res_mem[r_res_wr] <= {r_id_mem[r_id_rd], bus.tree_index_in};
  end

`ifdef TREE_SCHED_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stall;

  // Saturating counts of issues and of stalled cycles with pending requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_issue && r_stat_issued != '1) r_stat_issued <= r_stat_issued + 32'd1;
      if (r_state == S_RUN && |bus.req_valid && !w_issue && r_stat_stall != '1)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif
endmodule
